lcd_bus_receiver: RTL

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_pkg.sv | 65 ++++++
 rtl/lcd_bus_receiver_if.sv | 15 +
 rtl/lcd_strobe_monitor.sv | 68 ++++++
 rtl/lcd_bus_receiver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, error codes, command masks and DDRAM address constants
// for the LCD bus receiver.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERON,
    ST_INIT1,
    ST_INIT2,
    ST_INIT3,
    ST_INIT4,
    ST_HIGH_NIB,
    ST_LOW_NIB
  } lcdState_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_POWERON     = 3'd1,
    ERR_SHORT_PULSE = 3'd2,
    ERR_UNSTABLE    = 3'd3,
    ERR_GAP         = 3'd4,
    ERR_BAD_INIT    = 3'd5,
    ERR_READ        = 3'd6
  } lcdErr_t;

  // Init nibbles: three wake-ups then the switch to 4-bit mode.
  localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  // Command decode: (byte & MASK) == MATCH.
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] CMD_ENTRY      = 8'h04;
  localparam logic [7:0] CMD_ONOFF_MASK = 8'hF8;
  localparam logic [7:0] CMD_ONOFF      = 8'h08;
  localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
  localparam logic [7:0] CMD_DDRAM      = 8'h80;

  // Visible DDRAM windows of the two display lines.
  localparam logic [6:0] ADDR_LINE0_FIRST = 7'h00;
  localparam logic [6:0] ADDR_LINE0_LAST  = 7'h27;
  localparam logic [6:0] ADDR_LINE1_FIRST = 7'h40;
  localparam logic [6:0] ADDR_LINE1_LAST  = 7'h67;

  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

  // Cursor step after a data write; jumps between the two line windows.
  function automatic logic [6:0] stepAddr(input logic [6:0] addr, input logic increment);
    logic [6:0] result;
    if (increment) begin
      if (addr == ADDR_LINE0_LAST)      result = ADDR_LINE1_FIRST;
      else if (addr == ADDR_LINE1_LAST) result = ADDR_LINE0_FIRST;
      else                              result = addr + 7'd1;
    end else begin
      if (addr == ADDR_LINE1_FIRST)      result = ADDR_LINE0_LAST;
      else if (addr == ADDR_LINE0_FIRST) result = ADDR_LINE1_LAST;
      else                               result = addr - 7'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// HD44780-style 4-bit LCD bus as seen by the receiver.
interface lcd_bus_receiver_if;
  logic       iLCD_Enabled;
  logic       iLCD_RegisterSelect;
  logic       iLCD_ReadWrite;
  logic [3:0] iLCD_Data;

  modport master (
    output iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data
  );

  modport slave (
    input iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data
  );
endinterface

// File: rtl/lcd_strobe_monitor.sv
// E strobe monitor: edge detection, nibble capture, pulse-width and
// stability checks, and the inter-nibble gap counter.
module lcd_strobe_monitor
  import lcd_pkg::*;
#(
  parameter int unsigned T_EPULSE = 12
) (
  input  logic                 Clock,
  input  logic                 Reset,
  lcd_bus_receiver_if.slave    lcdBus,
  input  logic [31:0]          gapRequired,
  output logic                 nibValid,
  output logic [3:0]           nibble,
  output logic                 nibRs,
  output logic                 shortPulse,
  output logic                 unstable,
  output logic                 readAttempt,
  output logic                 gapShort
);

  logic        eQ;
  logic [3:0]  nibReg;
  logic        rsReg;
  logic        rwSeen;
  logic [31:0] highCnt;
  logic [31:0] gapCnt;
  logic        rise;
  logic        fall;

  assign rise = lcdBus.iLCD_Enabled & ~eQ;
  assign fall = ~lcdBus.iLCD_Enabled & eQ;

  // Track E and capture the bus on every E-high cycle; the last one wins.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      eQ      <= 1'b0;
      nibReg  <= '0;
      rsReg   <= 1'b0;
      rwSeen  <= 1'b0;
      highCnt <= '0;
    end else begin
      eQ <= lcdBus.iLCD_Enabled;
      if (lcdBus.iLCD_Enabled) begin
        nibReg  <= lcdBus.iLCD_Data;
        rsReg   <= lcdBus.iLCD_RegisterSelect;
        rwSeen  <= rise ? lcdBus.iLCD_ReadWrite : (rwSeen | lcdBus.iLCD_ReadWrite);
        highCnt <= rise ? 32'd1 : satInc(highCnt);
      end
    end
  end

  // Gap counter: cleared by each accepted nibble, saturating otherwise.
  always_ff @(posedge Clock) begin
    if (Reset)         gapCnt <= '0;
    else if (nibValid) gapCnt <= '0;
    else               gapCnt <= satInc(gapCnt);
  end

  // A read strobe is flagged but its nibble is dropped.
  assign nibValid    = fall & ~rwSeen;
  assign nibble      = nibReg;
  assign nibRs       = rsReg;
  assign shortPulse  = fall & (highCnt < T_EPULSE);
  assign unstable    = lcdBus.iLCD_Enabled & eQ & (lcdBus.iLCD_Data != nibReg);
  assign readAttempt = lcdBus.iLCD_Enabled & lcdBus.iLCD_ReadWrite;
  assign gapShort    = rise & (gapCnt < gapRequired);

endmodule

// File: rtl/lcd_bus_receiver.sv
// LCD bus receiver: follows the 4-bit init handshake, assembles bytes from
// nibble pairs, tracks display-on / entry mode / DDRAM cursor, and records
// the first protocol timing error.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERON = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_NIB     = 50,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_EPULSE  = 12
) (
  input  logic              Clock,
  input  logic              Reset,
  lcd_bus_receiver_if.slave lcdBus,
  output logic              oByteValid,
  output logic [7:0]        oByte,
  output logic              oByteIsData,
  output logic              oInitDone,
  output logic              oDisplayOn,
  output logic [6:0]        oCursorAddr,
  output logic              oTimingError,
  output logic [2:0]        oErrorCode
);

  lcdState_t   state, stateNext;
  lcdErr_t     errCode;
  logic [31:0] gapRequired;
  logic        nibValid, nibRs, shortPulse, unstable, readAttempt, gapShort;
  logic [3:0]  nibble, hiNib;
  logic        hiRs, idFlag, longGap;
  logic        badInit, byteDone, rsMismatch;
  logic [7:0]  assembled;

  lcd_strobe_monitor #(
    .T_EPULSE(T_EPULSE)
  ) strobeMon (
    .Clock       (Clock),
    .Reset       (Reset),
    .lcdBus      (lcdBus),
    .gapRequired (gapRequired),
    .nibValid    (nibValid),
    .nibble      (nibble),
    .nibRs       (nibRs),
    .shortPulse  (shortPulse),
    .unstable    (unstable),
    .readAttempt (readAttempt),
    .gapShort    (gapShort)
  );

  assign byteDone   = (state == ST_LOW_NIB) & nibValid;
  assign assembled  = {hiNib, nibble};
  assign rsMismatch = byteDone & (nibRs != hiRs);

  // Minimum idle time owed before the next E rise in the current state.
  always_comb begin
    gapRequired = 32'(T_CMD);
    case (state)
      ST_POWERON: gapRequired = 32'(T_POWERON);
      ST_INIT1:   gapRequired = 32'(T_INIT1);
      ST_INIT2:   gapRequired = 32'(T_INIT2);
      ST_INIT3:   gapRequired = 32'(T_CMD);
      ST_LOW_NIB: gapRequired = 32'(T_NIB);
      default:    gapRequired = longGap ? 32'(T_CLEAR) : 32'(T_CMD);
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_POWERON;
    else       state <= stateNext;
  end

  // Next state: init handshake, then alternating high/low nibbles.
  always_comb begin
    stateNext = state;
    badInit   = 1'b0;
    case (state)
      ST_POWERON: if (nibValid) begin
        if (nibble == INIT_NIB_WAKE) stateNext = ST_INIT1;
        else                         badInit   = 1'b1;
      end
      ST_INIT1: if (nibValid) begin
        if (nibble == INIT_NIB_WAKE) stateNext = ST_INIT2;
        else                         badInit   = 1'b1;
      end
      ST_INIT2: if (nibValid) begin
        if (nibble == INIT_NIB_WAKE) stateNext = ST_INIT3;
        else                         badInit   = 1'b1;
      end
      ST_INIT3: if (nibValid) begin
        if (nibble == INIT_NIB_4BIT) stateNext = ST_INIT4;
        else                         badInit   = 1'b1;
      end
      ST_INIT4:    stateNext = ST_HIGH_NIB;
      ST_HIGH_NIB: if (nibValid) stateNext = ST_LOW_NIB;
      ST_LOW_NIB:  if (nibValid) stateNext = ST_HIGH_NIB;
      default:     stateNext = ST_POWERON;
    endcase
  end

  // Error code of this cycle; same-cycle coincidences resolve to the lowest code.
  always_comb begin
    errCode = ERR_NONE;
    if (readAttempt)                           errCode = ERR_READ;
    if (badInit)                               errCode = ERR_BAD_INIT;
    if (gapShort && (state != ST_POWERON))     errCode = ERR_GAP;
    if (unstable || rsMismatch)                errCode = ERR_UNSTABLE;
    if (shortPulse)                            errCode = ERR_SHORT_PULSE;
    if (gapShort && (state == ST_POWERON))     errCode = ERR_POWERON;
  end

  // Byte assembly, command decode and cursor tracking.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hiNib       <= '0;
      hiRs        <= 1'b0;
      idFlag      <= 1'b1;
      longGap     <= 1'b0;
      oByteValid  <= 1'b0;
      oByte       <= '0;
      oByteIsData <= 1'b0;
      oInitDone   <= 1'b0;
      oDisplayOn  <= 1'b0;
      oCursorAddr <= '0;
    end else begin
      oByteValid <= byteDone;
      if ((stateNext == ST_INIT4) && (state != ST_INIT4)) oInitDone <= 1'b1;
      if ((state == ST_HIGH_NIB) && nibValid) begin
        hiNib   <= nibble;
        hiRs    <= nibRs;
        longGap <= 1'b0;
      end
      if (byteDone) begin
        oByte       <= assembled;
        oByteIsData <= nibRs;
        if (nibRs) begin
          oCursorAddr <= stepAddr(oCursorAddr, idFlag);
        end else if ((assembled & CMD_DDRAM_MASK) == CMD_DDRAM) begin
          oCursorAddr <= assembled[6:0];
        end else if ((assembled & CMD_ONOFF_MASK) == CMD_ONOFF) begin
          oDisplayOn <= assembled[2];
        end else if ((assembled & CMD_ENTRY_MASK) == CMD_ENTRY) begin
          idFlag <= assembled[1];
        end else if ((assembled & CMD_HOME_MASK) == CMD_HOME) begin
          oCursorAddr <= '0;
        end else if (assembled == CMD_CLEAR) begin
          oCursorAddr <= '0;
          longGap     <= 1'b1;
        end
      end
    end
  end

  // Sticky error flag; only the first error code is kept.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oTimingError <= 1'b0;
      oErrorCode   <= '0;
    end else if (!oTimingError && (errCode != ERR_NONE)) begin
      oTimingError <= 1'b1;
      oErrorCode   <= errCode;
    end
  end

endmodule
